// File: rtl/regfile_write_controller_pkg.sv
// regfile_write_controller_pkg: shared state encoding and sizing for the write-port controller.
package regfile_write_controller_pkg;
    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;
    localparam int STARVE_LIMIT_DEF = 4;
    localparam int REGSIZE_DEF = 32;
    function automatic int addr_w(input int regsize);
        return $clog2(regsize);
    endfunction
endpackage

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: grants the write port to M by default, to A once it has starved long enough.
module rf_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int SW = 3
) (
    input  logic          run_i,
    input  logic          a_valid_i,
    input  logic          m_valid_i,
    input  logic [SW-1:0] starve_cnt_i,
    output logic          a_ready_o,
    output logic          m_ready_o
);
    logic a_first;
    always_comb begin
        a_first = starve_cnt_i == SW'(STARVE_LIMIT);
        a_ready_o = run_i && a_valid_i && (a_first || !m_valid_i);
        m_ready_o = run_i && m_valid_i && !(a_first && a_valid_i);
    end
endmodule

// File: rtl/regfile_write_controller.sv
// regfile_write_controller: zero-sweeps the register file after reset, then shares its
// single write port between the load unit and ALU writeback.
module regfile_write_controller
    import regfile_write_controller_pkg::*;
#(
    parameter int BITSIZE = 32,
    parameter int REGSIZE = REGSIZE_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    localparam int AW = addr_w(REGSIZE)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a_valid,
    input  logic [AW-1:0]      a_sel,
    input  logic [BITSIZE-1:0] a_data,
    output logic               a_ready,
    input  logic               m_valid,
    input  logic [AW-1:0]      m_sel,
    input  logic [BITSIZE-1:0] m_data,
    output logic               m_ready,
    output logic [AW-1:0]      WriteSelect,
    output logic [BITSIZE-1:0] WriteData,
    output logic               WriteEnable,
    output logic               init_done
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    state_e             state_q, state_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic [SW-1:0]      starve_q, starve_d;
    logic               we_q, we_d;
    logic [AW-1:0]      sel_q, sel_d;
    logic [BITSIZE-1:0] data_q, data_d;
    logic               done_q, done_d;
    logic               a_xfer, m_xfer;

    rf_wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .SW(SW)) u_arb (
        .run_i(state_q == RUN),
        .a_valid_i(a_valid),
        .m_valid_i(m_valid),
        .starve_cnt_i(starve_q),
        .a_ready_o(a_ready),
        .m_ready_o(m_ready)
    );

    always_comb begin
        a_xfer = a_valid && a_ready;
        m_xfer = m_valid && m_ready;
        state_d = state_q;
        idx_d = idx_q;
        done_d = done_q;
        we_d = 1'b0;
        sel_d = sel_q;
        data_d = data_q;
        starve_d = (a_valid && !a_ready) ?
                   (starve_q == SW'(STARVE_LIMIT) ? starve_q : starve_q + 1'b1) : '0;
        if (state_q == INIT) begin
            we_d = 1'b1;
            sel_d = idx_q;
            data_d = '0;
            idx_d = idx_q + 1'b1;
            if (idx_q == AW'(REGSIZE - 1)) begin
                state_d = RUN;
                done_d = 1'b1;
            end
        end else begin
            // writes to x0 complete the handshake but never reach the register file
            we_d = (a_xfer && a_sel != '0) || (m_xfer && m_sel != '0);
            if (we_d) begin
                sel_d = m_xfer ? m_sel : a_sel;
                data_d = m_xfer ? m_data : a_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            idx_q <= AW'(1);
            starve_q <= '0;
            we_q <= 1'b0;
            sel_q <= '0;
            data_q <= '0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            starve_q <= starve_d;
            we_q <= we_d;
            sel_q <= sel_d;
            data_q <= data_d;
            done_q <= done_d;
        end
    end

    assign WriteEnable = we_q;
    assign WriteSelect = sel_q;
    assign WriteData = data_q;
    assign init_done = done_q;
endmodule

// File: tb/tb_regfile_write_controller.sv
// tb_regfile_write_controller: directed and random checks against a cycle-level reference model.
module tb_regfile_write_controller;
    localparam int BW = 32;
    localparam int RS = 32;
    localparam int AW = 5;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_valid = 1'b0, m_valid = 1'b0;
    logic [AW-1:0] a_sel = '0, m_sel = '0;
    logic [BW-1:0] a_data = '0, m_data = '0;
    logic          a_ready, m_ready, WriteEnable, init_done;
    logic [AW-1:0] WriteSelect;
    logic [BW-1:0] WriteData;

    regfile_write_controller #(.BITSIZE(BW), .REGSIZE(RS), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_sel(a_sel), .a_data(a_data), .a_ready(a_ready),
        .m_valid(m_valid), .m_sel(m_sel), .m_data(m_data), .m_ready(m_ready),
        .WriteSelect(WriteSelect), .WriteData(WriteData),
        .WriteEnable(WriteEnable), .init_done(init_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit in_init, e_we, e_done;
    int swept, starve, e_sel;
    logic [BW-1:0] e_data;
    bit ax, mx;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        in_init = 1; swept = 0; starve = 0; e_we = 0; e_done = 0;
    endtask

    // One cycle from a negedge to the next: check readys, advance the model, check outputs.
    task automatic step(input string tag, output bit a_won, output bit m_won);
        #1;
        a_won = !in_init && a_valid && (starve >= LIM || !m_valid);
        m_won = !in_init && m_valid && !a_won;
        chk({tag, ".a_ready"}, a_ready, a_won);
        chk({tag, ".m_ready"}, m_ready, m_won);
        @(posedge clk);
        if (in_init) begin
            swept++;
            e_we = 1; e_sel = swept; e_data = '0;
            if (swept == RS - 1) begin in_init = 0; e_done = 1; end
        end else begin
            e_we = 0;
            if (a_won && a_sel != 0) begin e_we = 1; e_sel = a_sel; e_data = a_data; end
            if (m_won && m_sel != 0) begin e_we = 1; e_sel = m_sel; e_data = m_data; end
        end
        starve = (a_valid && !a_won) ? (starve < LIM ? starve + 1 : LIM) : 0;
        @(negedge clk);
        chk({tag, ".we"}, WriteEnable, e_we);
        chk({tag, ".init_done"}, init_done, e_done);
        if (e_we) begin
            chk({tag, ".sel"}, WriteSelect, e_sel);
            chk({tag, ".data"}, WriteData, e_data);
        end
    endtask

    initial begin
        m_valid = 1; m_sel = 9; m_data = 32'h55;
        repeat (2) @(negedge clk);
        chk("rst.we", WriteEnable, 0);
        chk("rst.done", init_done, 0);
        chk("rst.m_ready", m_ready, 0);
        model_reset();
        rst = 0;
        for (int i = 0; i < RS - 1; i++) step("init", ax, mx);
        chk("init.done_after_sweep", init_done, 1);
        step("first_run", ax, mx);
        chk("first_run.m_took", mx, 1);
        m_valid = 0;
        step("idle", ax, mx);

        a_valid = 1; a_sel = 5; a_data = 32'hDEADBEEF;
        step("t2", ax, mx);
        chk("t2.sel", WriteSelect, 5);
        chk("t2.data", WriteData, 32'hDEADBEEF);
        a_valid = 0;
        step("t2.after", ax, mx);

        a_valid = 1; a_sel = 3; a_data = 32'hA3;
        m_valid = 1; m_sel = 4; m_data = 32'h1234;
        step("t3.m", ax, mx);
        chk("t3.sel", WriteSelect, 4);
        m_valid = 0;
        step("t3.a", ax, mx);
        chk("t3.a_took", ax, 1);
        a_valid = 0;

        a_valid = 1; m_valid = 1;
        for (int k = 0; k < 10; k++) begin
            m_sel = AW'(k + 10); m_data = 32'h100 + k;
            step("t4", ax, mx);
            chk("t4.a_win", ax, (k == 4 || k == 9));
            if (ax) begin a_sel = AW'(k + 20); a_data = 32'h200 + k; end
        end
        a_valid = 0; m_valid = 0;
        step("idle", ax, mx);

        m_valid = 1; m_sel = 0; m_data = 32'hFFFFFFFF;
        step("t5", ax, mx);
        chk("t5.m_ready_seen", mx, 1);
        m_valid = 0;

        for (int i = 0; i < 400; i++) begin
            if (!a_valid || ax) begin
                a_valid = $urandom_range(0, 9) < 7;
                a_sel = AW'($urandom_range(0, RS - 1));
                a_data = $urandom;
            end
            if (!m_valid || mx) begin
                m_valid = $urandom_range(0, 9) < 6;
                m_sel = AW'($urandom_range(0, RS - 1));
                m_data = $urandom;
            end
            step("rand", ax, mx);
        end

        a_valid = 1; a_sel = 7; a_data = 32'h77; m_valid = 0;
        step("t6.pre", ax, mx);
        if (!ax) step("t6.pre2", ax, mx);
        m_valid = 1; m_sel = 8;
        rst = 1;
        #1;
        chk("t6.we", WriteEnable, 0);
        chk("t6.done", init_done, 0);
        chk("t6.a_ready", a_ready, 0);
        chk("t6.m_ready", m_ready, 0);
        model_reset();
        @(negedge clk);
        rst = 0; a_valid = 0; m_valid = 0;
        for (int i = 0; i < RS - 1; i++) step("reinit", ax, mx);
        chk("reinit.done", init_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
